// File: rtl/uart_host_pkg.sv
// Shared types and constants for the host-side UART pin sequencer and the tapeout wrapper.
package uart_host_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RATE_W = 2;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'd0,
    OP_READ     = 2'd1,
    OP_CLEAR    = 2'd2,
    OP_SET_RATE = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    RW_IDLE    = 2'd0,
    RW_TO_TX   = 2'd1,
    RW_FROM_RX = 2'd2,
    RW_CLEAR   = 2'd3
  } ren_wen_t;

  localparam logic [RATE_W-1:0] RATE_DEFAULT = 2'd0;
  localparam logic [RATE_W-1:0] RATE_9600    = 2'd1;
  localparam logic [RATE_W-1:0] RATE_50000   = 2'd2;
  localparam logic [RATE_W-1:0] RATE_115200  = 2'd3;

  // Pulse code the wrapper expects for each pin-level command; SET_RATE never pulses.
  function automatic ren_wen_t op_to_ren_wen(input op_t op);
    ren_wen_t rw;
    case (op)
      OP_WRITE: rw = RW_TO_TX;
      OP_READ:  rw = RW_FROM_RX;
      OP_CLEAR: rw = RW_CLEAR;
      default:  rw = RW_IDLE;
    endcase
    return rw;
  endfunction

endpackage

// File: rtl/uart_pin_sequencer_if.sv
// Command and response handshake channels between a host and the UART pin sequencer.
interface uart_pin_sequencer_if;
  import uart_host_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  op_t               cmd_op;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/uart_pin_sequencer.sv
// Drives the tapeout UART wrapper pins: one-shot ren_wen pulse, IDLE gap, READ byte capture.
module uart_pin_sequencer
  import uart_host_pkg::*;
#(
  parameter int unsigned        GAP_CYCLES = 1,
  parameter logic [RATE_W-1:0]  RATE_RESET = RATE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_pin_sequencer_if.slave  host,
  output logic [3:0]           control,
  output logic [DATA_W-1:0]    tx_data,
  input  logic [DATA_W-1:0]    rx_data,
  output logic                 busy
);

  localparam int unsigned CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("uart_pin_sequencer: GAP_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              state, state_n;
  ren_wen_t            ren_wen, ren_wen_n;
  logic [RATE_W-1:0]   rate, rate_n;
  logic [DATA_W-1:0]   tx_data_n;
  logic [CNT_W-1:0]    gap_cnt, gap_cnt_n;
  logic                read_pend, read_pend_n;
  logic                rsp_valid_q, rsp_valid_n;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_n;
  logic                cmd_ready_q, cmd_ready_n;
  logic                busy_n;
  logic                accept;

  assign control        = {ren_wen, rate};
  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;

  // State and output registers; reset wins over every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ren_wen     <= RW_IDLE;
      rate        <= RATE_RESET;
      tx_data     <= '0;
      gap_cnt     <= '0;
      read_pend   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      ren_wen     <= ren_wen_n;
      rate        <= rate_n;
      tx_data     <= tx_data_n;
      gap_cnt     <= gap_cnt_n;
      read_pend   <= read_pend_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      cmd_ready_q <= cmd_ready_n;
      busy        <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    ren_wen_n   = ren_wen;
    rate_n      = rate;
    tx_data_n   = tx_data;
    gap_cnt_n   = gap_cnt;
    read_pend_n = read_pend;
    rsp_valid_n = rsp_valid_q;
    rsp_data_n  = rsp_data_q;
    accept      = host.cmd_valid && cmd_ready_q;

    if (rsp_valid_q && host.rsp_ready) begin
      rsp_valid_n = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (accept) begin
          if (host.cmd_op == OP_SET_RATE) begin
            rate_n = host.cmd_data[RATE_W-1:0];
          end else begin
            ren_wen_n = op_to_ren_wen(host.cmd_op);
            state_n   = S_PULSE;
            if (host.cmd_op == OP_WRITE) begin
              tx_data_n = host.cmd_data;
            end
          end
        end
      end
      S_PULSE: begin
        read_pend_n = (ren_wen == RW_FROM_RX);
        ren_wen_n   = RW_IDLE;
        gap_cnt_n   = CNT_W'(GAP_CYCLES - 1);
        state_n     = S_GAP;
      end
      S_GAP: begin
        // The wrapper presents the Rx byte only during the first gap cycle.
        if (read_pend) begin
          rsp_data_n  = rx_data;
          rsp_valid_n = 1'b1;
          read_pend_n = 1'b0;
        end
        if (gap_cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n   = S_IDLE;
        ren_wen_n = RW_IDLE;
      end
    endcase

    cmd_ready_n = (state_n == S_IDLE) && !rsp_valid_n;
    busy_n      = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_uart_pin_sequencer.sv
// Directed bench: pulse/response scoreboards on a GAP=1 instance plus timing checks on a GAP=3 instance.
module tb_uart_pin_sequencer;
  import uart_host_pkg::*;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] ctl_a, ctl_b;
  logic [7:0] tx_a, tx_b, rx_a, rx_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  logic [11:0] pulse_q_a[$];
  logic [7:0]  rsp_q_a[$];
  int          pulse_cyc_a[$];
  int          cyc_a = 0;
  logic [1:0]  exp_rate_a = 2'd0;
  logic [7:0]  exp_tx_a = 8'h00;

  always #5 clk = ~clk;

  uart_pin_sequencer_if ha ();
  uart_pin_sequencer_if hb ();

  uart_pin_sequencer #(.GAP_CYCLES(1), .RATE_RESET(RATE_DEFAULT)) dut_a (
    .clk(clk), .reset(rst_a), .host(ha), .control(ctl_a),
    .tx_data(tx_a), .rx_data(rx_a), .busy(busy_a)
  );

  uart_pin_sequencer #(.GAP_CYCLES(3), .RATE_RESET(RATE_9600)) dut_b (
    .clk(clk), .reset(rst_b), .host(hb), .control(ctl_b),
    .tx_data(tx_b), .rx_data(rx_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command to instance A until accepted; leaves the bench in the pulse cycle.
  task automatic send_a(input op_t op, input logic [7:0] d, input bit keep);
    int   n;
    logic rdy;
    case (op)
      OP_WRITE: begin
        exp_tx_a = d;
        pulse_q_a.push_back({2'd1, exp_rate_a, d});
      end
      OP_READ:     pulse_q_a.push_back({2'd2, exp_rate_a, exp_tx_a});
      OP_CLEAR:    pulse_q_a.push_back({2'd3, exp_rate_a, exp_tx_a});
      OP_SET_RATE: exp_rate_a = d[1:0];
      default:     ;
    endcase
    ha.cmd_valid = 1'b1;
    ha.cmd_op    = op;
    ha.cmd_data  = d;
    n = 0;
    do begin
      rdy = ha.cmd_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    check("send_a_accept", 32'(rdy), 1);
    if (!keep) ha.cmd_valid = 1'b0;
  endtask

  // Pulse scoreboard for instance A.
  initial begin
    logic [11:0] e;
    logic        was_pulse;
    logic [7:0]  last_tx;
    was_pulse = 1'b0;
    last_tx   = 8'h00;
    forever begin
      @(negedge clk);
      cyc_a++;
      if (rst_a) begin
        was_pulse = 1'b0;
      end else begin
        if (was_pulse) begin
          check("rw_idle_after_pulse", 32'(ctl_a[3:2]), 0);
          check("tx_hold_after_pulse", 32'(tx_a), 32'(last_tx));
        end
        was_pulse = 1'b0;
        if (ctl_a[3:2] != 2'b00) begin
          was_pulse = 1'b1;
          pulse_cyc_a.push_back(cyc_a);
          if (pulse_q_a.size() == 0) begin
            check("pulse_unexpected", 32'(pulse_q_a.size()), 1);
          end else begin
            e = pulse_q_a.pop_front();
            last_tx = e[7:0];
            check("pulse_control", 32'(ctl_a), 32'(e[11:8]));
            check("pulse_tx", 32'(tx_a), 32'(e[7:0]));
          end
        end
      end
    end
  end

  // Response scoreboard for instance A: compares on every accepted response.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_a && ha.rsp_valid && ha.rsp_ready) begin
        if (rsp_q_a.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_q_a.size()), 1);
        end else begin
          e = rsp_q_a.pop_front();
          check("rsp_data", 32'(ha.rsp_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rx_a = 8'h00; rx_b = 8'h00;
    ha.cmd_valid = 1'b0; ha.cmd_op = OP_WRITE; ha.cmd_data = 8'h00; ha.rsp_ready = 1'b0;
    hb.cmd_valid = 1'b0; hb.cmd_op = OP_WRITE; hb.cmd_data = 8'h00; hb.rsp_ready = 1'b0;
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0;

    check("rst_ctl_a", 32'(ctl_a), 'h0);
    check("rst_ctl_b", 32'(ctl_b), 'h1);
    check("rst_tx_a", 32'(tx_a), 'h0);
    check("rst_rsp_valid", 32'(ha.rsp_valid), 0);
    check("rst_rsp_data", 32'(ha.rsp_data), 'h0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_cmd_ready", 32'(ha.cmd_ready), 1);

    // WRITE A5: pulse in cycle 1, data held through cycle 2, ready in cycle 3.
    send_a(OP_WRITE, 8'hA5, 1'b0);
    check("t1_pulse", 32'(ctl_a), 'h4);
    check("t1_tx_c1", 32'(tx_a), 'hA5);
    tick();
    check("t1_gap_rw", 32'(ctl_a[3:2]), 0);
    check("t1_tx_c2", 32'(tx_a), 'hA5);
    check("t1_ready_c2", 32'(ha.cmd_ready), 0);
    check("t1_busy_c2", 32'(busy_a), 1);
    tick();
    check("t1_ready_c3", 32'(ha.cmd_ready), 1);
    check("t1_busy_c3", 32'(busy_a), 0);

    // READ with 3C only in the wrapper action cycle; stall the response channel.
    rsp_q_a.push_back(8'h3C);
    send_a(OP_READ, 8'h00, 1'b0);
    check("t2_pulse", 32'(ctl_a), 'h8);
    rx_a = 8'hEE;
    tick();
    rx_a = 8'h3C;
    check("t2_rsp_c2", 32'(ha.rsp_valid), 0);
    tick();
    rx_a = 8'h77;
    check("t2_rsp_valid_c3", 32'(ha.rsp_valid), 1);
    check("t2_rsp_data_c3", 32'(ha.rsp_data), 'h3C);
    ha.cmd_valid = 1'b1; ha.cmd_op = OP_WRITE; ha.cmd_data = 8'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall_valid", 32'(ha.rsp_valid), 1);
      check("t2_stall_data", 32'(ha.rsp_data), 'h3C);
      check("t2_stall_ready", 32'(ha.cmd_ready), 0);
      check("t2_stall_ctl", 32'(ctl_a), 'h0);
      check("t2_stall_tx", 32'(tx_a), 'hA5);
    end
    ha.cmd_valid = 1'b0;
    ha.rsp_ready = 1'b1;
    tick();
    ha.rsp_ready = 1'b0;
    check("t2_rsp_cleared", 32'(ha.rsp_valid), 0);
    check("t2_ready_back", 32'(ha.cmd_ready), 1);

    // SET_RATE 2 is single-cycle and persists through the next WRITE pulse.
    send_a(OP_SET_RATE, 8'h02, 1'b0);
    check("t3_rate", 32'(ctl_a), 'h2);
    check("t3_ready", 32'(ha.cmd_ready), 1);
    send_a(OP_WRITE, 8'h11, 1'b0);
    check("t3_pulse", 32'(ctl_a), 'h6);
    tick(); tick();

    // Four back-to-back WRITEs with cmd_valid held high.
    pulse_cyc_a.delete();
    send_a(OP_WRITE, 8'h01, 1'b1);
    send_a(OP_WRITE, 8'h02, 1'b1);
    send_a(OP_WRITE, 8'h03, 1'b1);
    send_a(OP_WRITE, 8'h04, 1'b0);
    repeat (3) tick();
    check("t4_pulse_count", 32'(pulse_cyc_a.size()), 4);
    for (int i = 1; i < 4; i++) begin
      if (i < pulse_cyc_a.size()) begin
        check("t4_pulse_spacing", 32'(pulse_cyc_a[i] - pulse_cyc_a[i-1]), 3);
      end
    end
    check("t4_tx_last", 32'(tx_a), 'h04);
    check("t4_ctl_idle", 32'(ctl_a), 'h2);

    // CLEAR keeps the last WRITE byte; READ with rsp_ready already high.
    send_a(OP_CLEAR, 8'h00, 1'b0);
    repeat (2) tick();
    check("t4c_tx_hold", 32'(tx_a), 'h04);
    ha.rsp_ready = 1'b1;
    rsp_q_a.push_back(8'hC3);
    send_a(OP_READ, 8'h00, 1'b0);
    tick();
    rx_a = 8'hC3;
    tick();
    rx_a = 8'h00;
    check("t4r_rsp_valid_c3", 32'(ha.rsp_valid), 1);
    check("t4r_ready_c3", 32'(ha.cmd_ready), 0);
    tick();
    check("t4r_rsp_done_c4", 32'(ha.rsp_valid), 0);
    check("t4r_ready_c4", 32'(ha.cmd_ready), 1);
    ha.rsp_ready = 1'b0;

    // Instance B, GAP_CYCLES=3: CLEAR pulse then three idle gap cycles.
    check("t5_ready_before", 32'(hb.cmd_ready), 1);
    hb.cmd_valid = 1'b1; hb.cmd_op = OP_CLEAR; hb.cmd_data = 8'h00;
    tick();
    hb.cmd_valid = 1'b0;
    check("t5_pulse", 32'(ctl_b), 'hD);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_gap_ctl", 32'(ctl_b), 'h1);
      check("t5_gap_ready", 32'(hb.cmd_ready), 0);
      check("t5_gap_busy", 32'(busy_b), 1);
    end
    tick();
    check("t5_ready_after", 32'(hb.cmd_ready), 1);
    check("t5_busy_after", 32'(busy_b), 0);

    // Instance B: reset during the gap of a READ discards the response and restores the rate.
    hb.cmd_valid = 1'b1; hb.cmd_op = OP_SET_RATE; hb.cmd_data = 8'h02;
    tick();
    hb.cmd_op = OP_READ; hb.cmd_data = 8'h00;
    check("t6_rate_set", 32'(ctl_b), 'h2);
    check("t6_ready", 32'(hb.cmd_ready), 1);
    tick();
    hb.cmd_valid = 1'b0;
    check("t6_pulse", 32'(ctl_b), 'hA);
    tick();
    rx_b = 8'h5A;
    check("t6_busy_gap", 32'(busy_b), 1);
    rst_b = 1'b1;
    tick();
    check("t6_rst_ctl", 32'(ctl_b), 'h1);
    check("t6_rst_rsp_valid", 32'(hb.rsp_valid), 0);
    check("t6_rst_rsp_data", 32'(hb.rsp_data), 'h0);
    check("t6_rst_busy", 32'(busy_b), 0);
    rst_b = 1'b0;
    check("t6_rst_ready", 32'(hb.cmd_ready), 1);
    tick();
    check("t6_post_rsp_valid", 32'(hb.rsp_valid), 0);
    check("t6_post_ready", 32'(hb.cmd_ready), 1);
    check("t6_post_ctl", 32'(ctl_b), 'h1);

    repeat (3) tick();
    check("rsp_q_drained", 32'(rsp_q_a.size()), 0);
    check("pulse_q_drained", 32'(pulse_q_a.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
